// File: rtl/alu_unit_if.sv
// Operand/result bundle between the execute-stage control and the ALU.
// The master drives operands and op; the slave (ALU) returns the registered result and flags.
interface alu_unit_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;

  modport master (
    output op, a, b,
    input  result, zero, carry, overflow
  );

  modport slave (
    input  op, a, b,
    output result, zero, carry, overflow
  );
endinterface

// File: rtl/alu_unit.sv
// Registered MIPS32 execute-stage ALU: one-cycle latency, a new op accepted every cycle.
// Result and flags are computed combinationally and captured on the rising edge.
module alu_unit #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  alu_unit_if.slave   bus
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOR  = 3'b101,
    OP_SLT  = 3'b110,
    OP_SLTU = 3'b111
  } op_e;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             add_ovf;
  logic             sub_ovf;
  logic             slt_bit;

  logic [WIDTH-1:0] res_p0;
  logic             carry_p0;
  logic             ovf_p0;

  logic [WIDTH-1:0] res_p1;
  logic             zero_p1;
  logic             carry_p1;
  logic             ovf_p1;

  // Signed less-than that stays correct when a - b overflows: differing signs decide directly.
  function automatic logic signed_lt(input logic sign_a, input logic sign_b,
                                     input logic diff_sign);
    if (sign_a != sign_b) begin
      return sign_a;
    end
    return diff_sign;
  endfunction

  assign sum_ext  = {1'b0, bus.a} + {1'b0, bus.b};
  // Bit WIDTH of the extended difference is the unsigned borrow (a < b).
  assign diff_ext = {1'b0, bus.a} - {1'b0, bus.b};

  assign add_ovf = (bus.a[MSB] == bus.b[MSB]) && (sum_ext[MSB]  != bus.a[MSB]);
  assign sub_ovf = (bus.a[MSB] != bus.b[MSB]) && (diff_ext[MSB] != bus.a[MSB]);
  assign slt_bit = signed_lt(bus.a[MSB], bus.b[MSB], diff_ext[MSB]);

  // Stage 0: combinational operation select
  always_comb begin
    res_p0   = '0;
    carry_p0 = 1'b0;
    ovf_p0   = 1'b0;
    case (op_e'(bus.op))
      OP_AND:  res_p0 = bus.a & bus.b;
      OP_OR:   res_p0 = bus.a | bus.b;
      OP_ADD: begin
        res_p0   = sum_ext[WIDTH-1:0];
        carry_p0 = sum_ext[WIDTH];
        ovf_p0   = add_ovf;
      end
      OP_SUB: begin
        res_p0   = diff_ext[WIDTH-1:0];
        carry_p0 = diff_ext[WIDTH];
        ovf_p0   = sub_ovf;
      end
      OP_XOR:  res_p0 = bus.a ^ bus.b;
      OP_NOR:  res_p0 = ~(bus.a | bus.b);
      OP_SLT:  res_p0 = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLTU: res_p0 = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH]};
      default: res_p0 = '0;
    endcase
  end

  // Stage 1: output registers, cleared asynchronously to the idle "zero result" state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p1   <= '0;
      zero_p1  <= 1'b1;
      carry_p1 <= 1'b0;
      ovf_p1   <= 1'b0;
    end else begin
      res_p1   <= res_p0;
      zero_p1  <= (res_p0 == '0);
      carry_p1 <= carry_p0;
      ovf_p1   <= ovf_p0;
    end
  end

  assign bus.result   = res_p1;
  assign bus.zero     = zero_p1;
  assign bus.carry    = carry_p1;
  assign bus.overflow = ovf_p1;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: the driver queues model predictions, the monitor
// pops one per clock edge that follows an issued operation and compares all outputs.
module tb_alu_unit;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        carry;
    logic        overflow;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  exp_t sb_q[$];

  alu_unit_if #(.WIDTH(32)) bus ();

  alu_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain 64-bit integer arithmetic on the operand values.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned ur;
    longint          sa;
    longint          sb;
    longint          sr;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e = '0;
    case (op)
      3'd0: e.result = a & b;
      3'd1: e.result = a | b;
      3'd2: begin
        ur = ua + ub;
        sr = sa + sb;
        e.result   = ur[31:0];
        e.carry    = (ur >= 64'h1_0000_0000);
        e.overflow = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd3: begin
        sr = sa - sb;
        e.result   = a - b;
        e.carry    = (ua < ub);
        e.overflow = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd4: e.result = a ^ b;
      3'd5: e.result = ~(a | b);
      3'd6: e.result = (sa < sb) ? 32'd1 : 32'd0;
      default: e.result = (ua < ub) ? 32'd1 : 32'd0;
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, got, want);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_result"},   bus.result,          32'd0);
    check({tag, "_zero"},     {31'd0, bus.zero},     32'd1);
    check({tag, "_carry"},    {31'd0, bus.carry},    32'd0);
    check({tag, "_overflow"}, {31'd0, bus.overflow}, 32'd0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    sb_q.push_back(model(op, a, b));
  endtask

  task automatic sweep(input logic [2:0] op);
    logic [31:0] a;
    logic [31:0] b;
    a = 32'd0;
    b = 32'd0;
    for (int i = 0; i < 10000; i++) begin
      issue(op, a, b);
      a = a + 32'h2345_6789;
      b = b + 32'h3456_7891;
    end
  endtask

  function automatic logic [31:0] corner_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every edge that follows an issued operation presents exactly one result.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t want;
      exp_t got;
      want = sb_q.pop_front();
      got  = {bus.result, bus.zero, bus.carry, bus.overflow};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL alu_out: got r=%08h z=%0b c=%0b v=%0b expected r=%08h z=%0b c=%0b v=%0b",
                 got.result, got.zero, got.carry, got.overflow,
                 want.result, want.zero, want.carry, want.overflow);
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.op  = 3'd0;
    bus.a   = 32'd0;
    bus.b   = 32'd0;

    // Reset held with random inputs toggling across several edges
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.op = 3'($urandom);
      bus.a  = $urandom;
      bus.b  = $urandom;
      @(posedge clk);
      #1;
      check_cleared("reset");
    end

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_cleared("post_release");
    issue(3'd2, 32'd2, 32'd3);

    sweep(3'd2);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd2, 32'h7FFF_FFFF, 32'h0000_0001);

    sweep(3'd3);
    issue(3'd3, 32'h8000_0000, 32'h0000_0001);
    issue(3'd3, 32'h1234_5678, 32'h1234_5678);
    issue(3'd3, 32'h0000_0001, 32'h0000_0002);

    sweep(3'd0);
    sweep(3'd1);
    issue(3'd4, 32'hF0F0_F0F0, 32'hFFFF_0000);
    issue(3'd5, 32'h0000_0000, 32'h0000_0000);

    issue(3'd6, 32'hFFFF_FFFF, 32'h0000_0001);
    issue(3'd7, 32'hFFFF_FFFF, 32'h0000_0001);
    issue(3'd6, 32'h7FFF_FFFF, 32'h8000_0000);
    issue(3'd6, 32'h8000_0000, 32'h7FFF_FFFF);

    // Op changes every cycle with random and corner operands
    for (int i = 0; i < 3000; i++) begin
      issue(3'($urandom), corner_val(), corner_val());
    end

    // Mid-stream asynchronous reset pulse between edges
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_cleared("mid_reset");
    rst_n = 1'b1;
    #0.5;
    check_cleared("mid_release");
    issue(3'd3, 32'h0000_0005, 32'h0000_0007);
    issue(3'd1, 32'hA5A5_0000, 32'h0000_5A5A);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
